// File: rtl/boot_sequencer.sv
// Boot sequencer: loads the CHIP-8 fontset, streams a ROM image into main memory,
// clears VRAM, then reports system ready (or error on ROM overflow).
module boot_sequencer #(
  parameter int ADDR_W     = 12,
  parameter int FONT_BASE  = 0,
  parameter int ROM_BASE   = 'h200,
  parameter int ROM_MAX    = 3584,
  parameter int VRAM_AW    = 11,
  parameter int AUTO_START = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               rom_valid_in,
  input  logic [7:0]         rom_data_in,
  input  logic               rom_last_in,
  output logic               rom_ready_out,
  output logic               mem_we_out,
  output logic [ADDR_W-1:0]  mem_addr_out,
  output logic [7:0]         mem_data_out,
  output logic               vram_we_out,
  output logic [VRAM_AW-1:0] vram_addr_out,
  output logic               vram_data_out,
  output logic               system_ready_out,
  output logic               error_out
);

  localparam int ROM_CW = $clog2(ROM_MAX + 1);

  localparam logic [7:0] FONT_ROM [0:79] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [2:0] {
    S_IDLE, S_FONT, S_ROM, S_CLEAR, S_READY, S_ERROR
  } state_e;

  state_e              state_q;
  logic [6:0]          font_idx_q;
  logic [ROM_CW-1:0]   rom_cnt_q;
  logic [VRAM_AW-1:0]  vram_idx_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      font_idx_q <= '0;
      rom_cnt_q  <= '0;
      vram_idx_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in || (AUTO_START != 0)) begin
            state_q    <= S_FONT;
            font_idx_q <= '0;
          end
        end
        S_FONT: begin
          if (font_idx_q == 7'd79) begin
            state_q   <= S_ROM;
            rom_cnt_q <= '0;
          end else begin
            font_idx_q <= font_idx_q + 7'd1;
          end
        end
        S_ROM: begin
          // The byte is written this cycle; a last marker wins over overflow.
          if (rom_valid_in) begin
            if (rom_last_in) begin
              state_q    <= S_CLEAR;
              vram_idx_q <= '0;
            end else if (rom_cnt_q == ROM_CW'(ROM_MAX - 1)) begin
              state_q <= S_ERROR;
            end else begin
              rom_cnt_q <= rom_cnt_q + 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (vram_idx_q == '1) state_q <= S_READY;
          else                  vram_idx_q <= vram_idx_q + 1'b1;
        end
        S_READY, S_ERROR: begin
          if (start_in) begin
            state_q    <= S_FONT;
            font_idx_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ports decode straight from state so ROM writes land in the accepting cycle.
  always_comb begin
    rom_ready_out    = 1'b0;
    mem_we_out       = 1'b0;
    mem_addr_out     = '0;
    mem_data_out     = '0;
    vram_we_out      = 1'b0;
    vram_addr_out    = '0;
    system_ready_out = 1'b0;
    error_out        = 1'b0;
    case (state_q)
      S_FONT: begin
        mem_we_out   = 1'b1;
        mem_addr_out = ADDR_W'(FONT_BASE + int'(font_idx_q));
        mem_data_out = FONT_ROM[font_idx_q];
      end
      S_ROM: begin
        rom_ready_out = 1'b1;
        if (rom_valid_in) begin
          mem_we_out   = 1'b1;
          mem_addr_out = ADDR_W'(ROM_BASE + int'(rom_cnt_q));
          mem_data_out = rom_data_in;
        end
      end
      S_CLEAR: begin
        vram_we_out   = 1'b1;
        vram_addr_out = vram_idx_q;
      end
      S_READY: system_ready_out = 1'b1;
      S_ERROR: error_out        = 1'b1;
      default: ;
    endcase
  end

  assign vram_data_out = 1'b0;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: a default instance and a ROM_MAX=4 instance share
// one stimulus stream; observed write traces are compared against a reference list.
module tb_boot_sequencer;

  localparam int AW = 12;
  localparam int VW = 11;
  localparam int FB = 0;
  localparam int RB = 'h200;
  localparam int VDEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rom_valid = 1'b0;
  logic [7:0] rom_data = '0;
  logic       rom_last = 1'b0;

  logic          a_ready, a_mem_we, a_vram_we, a_vram_data, a_sys, a_err;
  logic [AW-1:0] a_mem_addr;
  logic [7:0]    a_mem_data;
  logic [VW-1:0] a_vram_addr;
  logic          b_ready, b_mem_we, b_vram_we, b_vram_data, b_sys, b_err;
  logic [AW-1:0] b_mem_addr;
  logic [7:0]    b_mem_data;
  logic [VW-1:0] b_vram_addr;

  boot_sequencer dut_a (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .rom_valid_in(rom_valid), .rom_data_in(rom_data), .rom_last_in(rom_last),
    .rom_ready_out(a_ready), .mem_we_out(a_mem_we), .mem_addr_out(a_mem_addr),
    .mem_data_out(a_mem_data), .vram_we_out(a_vram_we), .vram_addr_out(a_vram_addr),
    .vram_data_out(a_vram_data), .system_ready_out(a_sys), .error_out(a_err)
  );

  boot_sequencer #(.ROM_MAX(4)) dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .rom_valid_in(rom_valid), .rom_data_in(rom_data), .rom_last_in(rom_last),
    .rom_ready_out(b_ready), .mem_we_out(b_mem_we), .mem_addr_out(b_mem_addr),
    .mem_data_out(b_mem_data), .vram_we_out(b_vram_we), .vram_addr_out(b_vram_addr),
    .vram_data_out(b_vram_data), .system_ready_out(b_sys), .error_out(b_err)
  );

  logic [7:0] font_ref [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  // Observed write traces and port-hygiene counters, sampled on the falling edge.
  logic [19:0] tr_a[$];
  logic [19:0] tr_b[$];
  int vcnt_a = 0, vcnt_b = 0, vord_a = 0, vord_b = 0, viol_a = 0, viol_b = 0;

  always @(negedge clk) begin
    if (a_mem_we) tr_a.push_back({a_mem_addr, a_mem_data});
    else if (a_mem_addr != '0 || a_mem_data != '0) viol_a++;
    if (a_vram_we) begin
      if (a_vram_addr != VW'(vcnt_a % VDEPTH)) vord_a++;
      vcnt_a++;
    end else if (a_vram_addr != '0) viol_a++;
    if (a_vram_data != 1'b0) viol_a++;
  end

  always @(negedge clk) begin
    if (b_mem_we) tr_b.push_back({b_mem_addr, b_mem_data});
    else if (b_mem_addr != '0 || b_mem_data != '0) viol_b++;
    if (b_vram_we) begin
      if (b_vram_addr != VW'(vcnt_b % VDEPTH)) vord_b++;
      vcnt_b++;
    end else if (b_vram_addr != '0) viol_b++;
    if (b_vram_data != 1'b0) viol_b++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a boot writes the 80 font bytes in order, then the accepted ROM bytes.
  task automatic chk_trace(input string tag, input bit use_b, input int base,
                           input logic [7:0] rb[$], input int nrom);
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    logic [19:0] obs;
    if (use_b) obs_q = tr_b;
    else       obs_q = tr_a;
    for (int i = 0; i < 80; i++) exp_q.push_back({12'(FB + i), font_ref[i]});
    for (int n = 0; n < nrom; n++) exp_q.push_back({12'(RB + n), rb[n]});
    chk({tag, "_len"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (base + i < obs_q.size()) ? obs_q[base + i] : 20'hFFFFF;
      chk($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(exp_q[i]));
    end
  endtask

  task automatic chk_a_quiet(input string tag);
    chk({tag, "_rom_ready"}, 32'(a_ready), 0);
    chk({tag, "_mem_we"}, 32'(a_mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(a_mem_addr), 0);
    chk({tag, "_mem_data"}, 32'(a_mem_data), 0);
    chk({tag, "_vram_we"}, 32'(a_vram_we), 0);
    chk({tag, "_vram_addr"}, 32'(a_vram_addr), 0);
    chk({tag, "_sys_ready"}, 32'(a_sys), 0);
    chk({tag, "_error"}, 32'(a_err), 0);
  endtask

  // Sends bytes on the ROM stream with random idle gaps; returns #1 after the last accept.
  task automatic send(input logic [7:0] rb[$], input bit with_last);
    int w;
    for (int k = 0; k < rb.size(); k++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        rom_valid = 1'b0;
        @(posedge clk); #1;
      end
      rom_valid = 1'b1;
      rom_data  = rb[k];
      rom_last  = with_last && (k == rb.size() - 1);
      @(negedge clk);
      w = 0;
      while (!a_ready && w < 100) begin @(negedge clk); w++; end
      chk("rom_ready_wait", 32'(a_ready), 1);
      @(posedge clk); #1;
      $display("tb: rom byte k=%0d data=%02h last=%0b", k, rb[k], rom_last);
    end
    rom_valid = 1'b0;
    rom_last  = 1'b0;
  endtask

  task automatic wait_rom_ready(input string tag, output int n);
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 300) begin @(posedge clk); n++; @(negedge clk); end
    chk({tag, "_rom_ready"}, 32'(a_ready), 1);
  endtask

  // Waits for READY while driving garbage on the ROM stream and pulsing start mid-CLEAR.
  task automatic wait_sys_ready(input string tag, output int n);
    n = 0;
    while (!a_sys && n < 3000) begin
      @(posedge clk); #1;
      n++;
      rom_valid = 1'($urandom_range(0, 1));
      rom_data  = 8'($urandom);
      rom_last  = 1'($urandom_range(0, 1));
      start     = (n == 100);
      @(negedge clk);
    end
    rom_valid = 1'b0;
    rom_last  = 1'b0;
    start     = 1'b0;
    chk({tag, "_sys_ready"}, 32'(a_sys), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb[$];
    int n, base_a, base_b, v0a, v0b;

    // Reset state
    repeat (3) @(negedge clk);
    chk_a_quiet("reset");
    chk("reset_b_error", 32'(b_err), 0);

    // Release reset: auto-start into the font load
    @(posedge clk); #1;
    rst = 1'b0;
    base_a = tr_a.size(); base_b = tr_b.size();
    rb.delete();
    wait_rom_ready("boot1", n);
    chk("boot1_cycles", 32'(n), 81);
    chk_trace("boot1_a", 1'b0, base_a, rb, 0);
    chk("boot1_b_ready", 32'(b_ready), 1);

    // Gapped three-byte image, then VRAM clear with a start pulse mid-CLEAR
    rb = '{8'hAA, 8'hBB, 8'hCC};
    v0a = vcnt_a; v0b = vcnt_b;
    send(rb, 1'b1);
    wait_sys_ready("clear1", n);
    chk("clear1_cycles", 32'(n), VDEPTH);
    chk_trace("img1_a", 1'b0, base_a, rb, 3);
    chk_trace("img1_b", 1'b1, base_b, rb, 3);
    chk("clear1_vcnt_a", 32'(vcnt_a - v0a), VDEPTH);
    chk("clear1_vcnt_b", 32'(vcnt_b - v0b), VDEPTH);
    chk("ready1_error", 32'(a_err), 0);
    chk("ready1_rom_ready", 32'(a_ready), 0);
    chk("ready1_b_sys", 32'(b_sys), 1);

    // start in READY restarts FONT at index 0 on the next cycle
    base_a = tr_a.size(); base_b = tr_b.size();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart_sys_ready", 32'(a_sys), 0);
    chk("restart_mem_we", 32'(a_mem_we), 1);
    chk("restart_mem_addr", 32'(a_mem_addr), FB);
    chk("restart_mem_data", 32'(a_mem_data), 32'h0F0);
    rb.delete();
    wait_rom_ready("boot2", n);
    chk_trace("boot2_a", 1'b0, base_a, rb, 0);

    // Ten random bytes without last: the ROM_MAX=4 instance overflows after four
    for (int k = 0; k < 10; k++) rb.push_back(8'($urandom));
    send(rb, 1'b0);
    chk_trace("img2_a", 1'b0, base_a, rb, 10);
    chk_trace("img2_b", 1'b1, base_b, rb, 4);
    chk("ovf_b_error", 32'(b_err), 1);
    chk("ovf_b_rom_ready", 32'(b_ready), 0);
    chk("ovf_b_sys_ready", 32'(b_sys), 0);
    chk("ovf_a_rom_ready", 32'(a_ready), 1);
    chk("ovf_a_error", 32'(a_err), 0);

    // Asynchronous reset mid-ROM with a valid byte pending
    rom_valid = 1'b1;
    rom_data  = 8'h55;
    rst       = 1'b1;
    #1;
    chk_a_quiet("midrom_rst");
    chk("midrom_rst_b_error", 32'(b_err), 0);
    rom_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base_a = tr_a.size(); base_b = tr_b.size();
    rb.delete();
    wait_rom_ready("boot3", n);
    chk("boot3_cycles", 32'(n), 81);
    chk_trace("boot3_a", 1'b0, base_a, rb, 0);

    // Short random image after the reset starts again at ROM_BASE
    rb = '{8'($urandom), 8'($urandom)};
    v0a = vcnt_a;
    send(rb, 1'b1);
    wait_sys_ready("clear3", n);
    chk_trace("img3_a", 1'b0, base_a, rb, 2);
    chk_trace("img3_b", 1'b1, base_b, rb, 2);
    chk("clear3_vcnt_a", 32'(vcnt_a - v0a), VDEPTH);

    // Port hygiene gathered over the whole run
    chk("vram_order_a", 32'(vord_a), 0);
    chk("vram_order_b", 32'(vord_b), 0);
    chk("idle_ports_a", 32'(viol_a), 0);
    chk("idle_ports_b", 32'(viol_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL expose parameter ADDR_W, default 12, main-memory byte-address width.
REQ-002 SHALL expose parameter FONT_BASE, default 0, memory address of the first font byte.
REQ-003 SHALL expose parameter ROM_BASE, default 'h200, memory address of the first ROM byte.
REQ-004 SHALL expose parameter ROM_MAX, default 3584, maximum ROM bytes accepted.
REQ-005 SHALL expose parameter VRAM_AW, default 11, VRAM bit-address width (depth 2**VRAM_AW).
REQ-006 SHALL expose parameter AUTO_START, default 1, 1 = begin loading without start_in after reset.
REQ-007 clk_in  input  1  sole clock; all state changes on the rising edge.
REQ-008 rst_in  input  1  asynchronous, active-high reset.
REQ-009 start_in  input  1  single-cycle request to (re)run the boot sequence.
REQ-010 rom_valid_in  input  1  ROM stream byte valid.
REQ-011 rom_data_in  input  8  ROM stream byte.
REQ-012 rom_last_in  input  1  marks the final ROM byte; qualified by rom_valid_in.
REQ-013 rom_ready_out  output  1  sequencer accepts a ROM byte this cycle.
REQ-014 mem_we_out / mem_addr_out / mem_data_out  output  1 / ADDR_W / 8  main-memory write port.
REQ-015 vram_we_out / vram_addr_out / vram_data_out  output  1 / VRAM_AW / 1  VRAM write port.
REQ-016 system_ready_out  output  1  memory and VRAM fully initialised.
REQ-017 error_out  output  1  ROM overflowed ROM_MAX; sticky until restart.

Function
REQ-018 SHALL implement states IDLE, FONT, ROM, CLEAR, READY, ERROR.
REQ-019 IDLE SHALL go to FONT on start_in, or, if AUTO_START=1, on the first clock after reset release.
REQ-020 FONT SHALL write the 80-byte standard CHIP-8 hex fontset (glyphs 0..F, 5 bytes each), one byte per cycle, index i to FONT_BASE+i, i = 0..79 ascending.
REQ-021 Font bytes SHALL match the standard set, e.g. i=0 F0, i=5 20, i=50 F0, i=55 E0, i=79 80.
REQ-022 After writing i=79, FONT SHALL go to ROM on the next clock.
REQ-023 In ROM, rom_ready_out SHALL be 1 combinationally; a byte is accepted only when rom_valid_in & rom_ready_out on a rising edge.
REQ-024 Accepted byte n (0-based) SHALL be written in the same cycle to ROM_BASE+n; address arithmetic truncates to ADDR_W bits.
REQ-025 An accepted byte with rom_last_in=1 SHALL be written and the state SHALL go to CLEAR.
REQ-026 Accepted byte n=ROM_MAX-1 without rom_last_in SHALL be written, then the state SHALL go to ERROR.
REQ-027 CLEAR SHALL write 0 to VRAM addresses 0..2**VRAM_AW-1 ascending, one per cycle, then go to READY.
REQ-028 system_ready_out SHALL be 1 only in READY; error_out SHALL be 1 only in ERROR.
REQ-029 start_in in READY or ERROR SHALL restart at FONT next cycle, dropping system_ready_out/error_out that cycle.
REQ-030 start_in in FONT, ROM or CLEAR SHALL be ignored.
REQ-031 mem_we_out SHALL be 1 only during FONT writes and accepted ROM bytes; vram_we_out only in CLEAR; vram_data_out SHALL be 0.
REQ-032 When a write enable is 0, its address and data outputs SHALL be 0.
REQ-033 rom_valid_in outside ROM SHALL be ignored and cause no write.

Reset
REQ-034 rst_in=1 SHALL asynchronously force IDLE, clear all counters, and drive every output to 0.
REQ-035 Reset asserted mid-FONT, ROM or CLEAR SHALL abandon the sequence; after release, the full sequence SHALL restart from font index 0.

Verification
REQ-036 AUTO_START=1, release reset -> 80 mem writes, addr 0..79, data F0 at addr 0 and 80 at addr 79, then rom_ready_out=1.
REQ-037 Stream 3 bytes AA,BB,CC with last on CC, valid gapped -> writes at 200,201,202; 2048 VRAM zero writes; system_ready_out=1.
REQ-038 ROM_MAX=4, 4 bytes without last -> 4 writes 200..203, then error_out=1, rom_ready_out=0, system_ready_out=0.
REQ-039 start_in pulse in READY and during CLEAR -> READY restarts FONT next cycle; CLEAR pulse has no effect.
REQ-040 rst_in pulse during ROM after 10 bytes -> outputs 0 immediately; after release, FONT restarts at index 0 and ROM at 200.
